calc_alu_seq: RTL

Multi-cycle arithmetic unit of the calculator datapath. Sits directly downstream of the two digit registers (operand A and operand B, each 10 packed hex digits, digit 0 in bits [3:0]). It latches both 40-bit operands on a start pulse, computes add, subtract, multiply or divide, and presents a registered 40-bit result with status flags to the display stage.

---
 rtl/calc_alu_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: multi-cycle unsigned arithmetic unit of the calculator datapath.
// Latches two packed-hex operands on a start pulse and computes add, subtract,
// multiply (shift-add) or divide (restoring), presenting a registered result
// with carry/borrow/overflow and divide-by-zero status.
module calc_alu_seq #(
  parameter int WIDTH = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             C,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  // Control state
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  op_t             op_q,    op_d;
  logic            dz_q,    dz_d;     // divide-by-zero result still to be written

  // Latched operands
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  // Iteration registers: {hi, lo} is the 2*WIDTH partial product for multiply;
  // hi is the partial remainder and lo the dividend/quotient shift register for divide.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Next values of the visible status registers
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;
  logic             err_d;

  // Single-cycle add/subtract
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;

  // One shift-add multiply step: add A into the upper half when the current
  // multiplier bit is set, then shift the whole product right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  // One restoring-divide step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, and shift the resulting quotient bit in.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff = a_q - b_q;

  assign mul_sum  = {1'b0, hi_q} + ({1'b0, a_q} & {(WIDTH + 1){lo_q[0]}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  // The difference is only used when it fits, so it is always below B and
  // the low WIDTH bits of the subtraction are exact.
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;
  assign div_hi_n  = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_n  = {lo_q[WIDTH-2:0], div_ge};

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE) && !dz_q;

  // Next-state, datapath step and status update; clear key overrides everything.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dz_d     = dz_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result;
    ovf_d    = ovf;
    err_d    = err;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = A;
          b_d   = B;
          op_d  = op_t'(op);
          cnt_d = CNT_LOAD;
          hi_d  = '0;
          lo_d  = (op_t'(op) == OP_DIV) ? A : B;
          if ((op_t'(op) == OP_DIV) && (B == '0)) begin
            // Skip RUN; the zero result is written on the following edge.
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        case (op_q)
          OP_ADD: begin
            result_d = add_sum[WIDTH-1:0];
            ovf_d    = add_sum[WIDTH];
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = sub_diff;
            ovf_d    = (a_q < b_q);
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
          OP_MUL: begin
            hi_d = mul_hi_n;
            lo_d = mul_lo_n;
            if (cnt_q == '0) begin
              result_d = mul_lo_n;
              ovf_d    = |mul_hi_n;
              err_d    = 1'b0;
              state_d  = S_DONE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          OP_DIV: begin
            hi_d = div_hi_n;
            lo_d = div_lo_n;
            if (cnt_q == '0) begin
              result_d = div_lo_n;
              ovf_d    = 1'b0;
              err_d    = 1'b0;
              state_d  = S_DONE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        endcase
      end

      S_DONE: begin
        if (dz_q) begin
          result_d = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b1;
          dz_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (C) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      dz_d     = 1'b0;
      result_d = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
    end
  end

  // State, operand, iteration and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      result  <= result_d;
      ovf     <= ovf_d;
      err     <= err_d;
    end
  end

endmodule
